// File: rtl/ysyx_24080018_pkg.sv
// Shared definitions for the ysyx_24080018 instruction fetch slice:
// default reset PC, datapath width and the fetch FSM state encoding.
package ysyx_24080018_pkg;

  localparam int          INST_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ysyx_24080018_pc_reg.sv
// Program counter register with its next-PC selection:
// a word-aligned redirect target wins over the sequential pc+4 step.
module ysyx_24080018_pc_reg
  import ysyx_24080018_pkg::*;
#(
  parameter int              INST_W   = INST_W_DEFAULT,
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc,
  output logic [INST_W-1:0] pc
);

  logic [INST_W-1:0] pc_r;
  logic [INST_W-1:0] pc_next_s;

  // Next-PC selection; the low two redirect bits are forced to zero.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = redirect_pc & ~INST_W'(32'd3);
    end else if (advance) begin
      pc_next_s = pc_r + INST_W'(32'd4);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/ysyx_24080018_fetch.sv
// Instruction fetch stage: one outstanding memory read at a time, a held
// output instruction for decode, and redirects that squash in-flight fetches.
module ysyx_24080018_fetch
  import ysyx_24080018_pkg::*;
#(
  parameter int                INST_W   = INST_W_DEFAULT,
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  output logic [INST_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INST_W-1:0] ins,
  output logic [INST_W-1:0] ins_pc,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc
);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic              drop_r;
  logic              drop_next_s;
  logic              capture_s;
  logic              accept_s;
  logic [INST_W-1:0] pc_s;
  logic              ins_valid_r;
  logic [INST_W-1:0] ins_r;
  logic [INST_W-1:0] ins_pc_r;

  ysyx_24080018_pc_reg #(
    .INST_W   (INST_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .advance        (capture_s),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc_s)
  );

  assign req_valid = (state_r == ST_REQ) && !rst;
  assign req_addr  = pc_s;
  assign accept_s  = req_valid && req_ready;

  // Next-state, drop-flag and capture decisions; redirect outranks all else.
  always_comb begin
    state_next_s = state_r;
    drop_next_s  = drop_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (accept_s) begin
          state_next_s = ST_WAIT;
          drop_next_s  = redirect_valid;
        end else begin
          state_next_s = ST_REQ;
          drop_next_s  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_next_s = resp_valid ? ST_REQ : ST_WAIT;
          drop_next_s  = !resp_valid;
        end else if (resp_valid) begin
          if (drop_r) begin
            state_next_s = ST_REQ;
            drop_next_s  = 1'b0;
          end else begin
            state_next_s = ST_HOLD;
            capture_s    = 1'b1;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || ins_ready) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_REQ;
        drop_next_s  = 1'b0;
      end
    endcase
  end

  // FSM state and drop flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_REQ;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      drop_r  <= drop_next_s;
    end
  end

  // Output instruction register toward decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_valid_r <= 1'b0;
      ins_r       <= '0;
      ins_pc_r    <= '0;
    end else begin
      ins_valid_r <= (state_next_s == ST_HOLD);
      if (capture_s) begin
        ins_r    <= resp_data;
        ins_pc_r <= pc_s;
      end
    end
  end

  assign ins_valid = ins_valid_r;
  assign ins       = ins_r;
  assign ins_pc    = ins_pc_r;

endmodule

// File: tb/tb_ysyx_24080018_fetch.sv
// Directed bench for the fetch stage: a latency-programmable memory, an
// abstract fetch model checked every cycle, and hand-computed pinned values.
module tb_ysyx_24080018_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, ins_valid, ins_ready, redirect_valid;
  logic [31:0] req_addr, resp_data, ins, ins_pc, redirect_pc;

  int total = 0;
  int bad   = 0;

  // memory model state (driven only by the main initial)
  bit          mem_busy;
  int          mem_cnt;
  int          lat;
  bit          poison;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  ysyx_24080018_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (poison) return POISON;
    else if (a == RST_PC) return 32'h0000_0413;
    else return {a[15:0], 16'hA5A5};
  endfunction

  // One clock: note acceptances mid-cycle, then drive next cycle's response.
  task automatic tick();
    @(negedge clk);
    if (req_valid && req_ready) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = req_addr;
    end
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(mem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic wait_ins(int budget);
    int n = 0;
    while (!ins_valid && n < budget) begin
      tick();
      n++;
    end
    check_bit("wait_ins_timeout", ins_valid, 1'b1);
  endtask

  task automatic wait_resp(int budget);
    int n = 0;
    while (!resp_valid && n < budget) begin
      tick();
      n++;
    end
    check_bit("wait_resp_timeout", resp_valid, 1'b1);
  endtask

  // Abstract model: a redirect kills any fetch in flight; a surviving
  // response becomes the held instruction and the next fetch is its pc+4.
  initial begin
    logic [31:0] exp_pc, out_addr, exp_ins, exp_ins_pc;
    bit outstanding, killed, exp_iv, exp_rv, acc, resp, deliver;
    exp_pc = RST_PC; out_addr = '0; exp_ins = '0; exp_ins_pc = '0;
    outstanding = 0; killed = 0; exp_iv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check_bit("rst_req_valid", req_valid, 1'b0);
        check_bit("rst_ins_valid", ins_valid, 1'b0);
        check("rst_ins", ins, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);
        exp_pc = RST_PC; outstanding = 0; killed = 0; exp_iv = 0;
      end else begin
        exp_rv = !outstanding && !exp_iv;
        check_bit("model_req_valid", req_valid, exp_rv);
        if (exp_rv) check("model_req_addr", req_addr, exp_pc);
        check_bit("model_ins_valid", ins_valid, exp_iv);
        if (exp_iv) begin
          check("model_ins", ins, exp_ins);
          check("model_ins_pc", ins_pc, exp_ins_pc);
        end
        acc     = exp_rv && req_ready;
        resp    = outstanding && resp_valid;
        deliver = resp && !killed && !redirect_valid;
        if (exp_iv && (ins_ready || redirect_valid)) exp_iv = 0;
        if (resp) outstanding = 0;
        if (deliver) begin
          exp_iv     = 1;
          exp_ins    = resp_data;
          exp_ins_pc = out_addr;
          exp_pc     = out_addr + 32'd4;
        end
        if (acc) begin
          outstanding = 1;
          out_addr    = exp_pc;
          killed      = redirect_valid;
        end else if (redirect_valid) begin
          killed = 1;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  initial begin
    logic [31:0] held_ins, held_pc;
    rst = 1'b1; req_ready = 1'b0; ins_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mem_busy = 0; mem_cnt = 0; lat = 1; poison = 0; mem_addr = '0;
    repeat (3) tick();
    check_bit("lit_rst_req_valid", req_valid, 1'b0);

    // basic fetch, 1-cycle memory
    rst = 1'b0; req_ready = 1'b1; ins_ready = 1'b1;
    #1;
    check_bit("lit_first_req_valid", req_valid, 1'b1);
    check("lit_first_req_addr", req_addr, 32'h8000_0000);
    tick();
    tick();
    check_bit("lit_first_ins_valid", ins_valid, 1'b1);
    check("lit_first_ins", ins, 32'h0000_0413);
    check("lit_first_ins_pc", ins_pc, 32'h8000_0000);
    tick();
    check("lit_second_req_addr", req_addr, 32'h8000_0004);

    // decode stall in HOLD
    ins_ready = 1'b0;
    wait_ins(10);
    held_ins = ins;
    held_pc  = ins_pc;
    check("lit_stall_ins", held_ins, 32'h0004_A5A5);
    check("lit_stall_ins_pc", held_pc, 32'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ins_const", ins, held_ins);
      check("stall_pc_const", ins_pc, held_pc);
      check_bit("stall_no_req", req_valid, 1'b0);
    end
    ins_ready = 1'b1; req_ready = 1'b0;
    tick();
    check("lit_after_stall_addr", req_addr, 32'h8000_0008);

    // redirect while waiting, then a poisoned response that must be dropped
    lat = 3; poison = 1; req_ready = 1'b1;
    tick();
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    wait_resp(10);
    poison = 0;
    check_bit("drop_no_ins_valid", ins_valid, 1'b0);
    tick();
    check_bit("drop_ins_valid_after", ins_valid, 1'b0);
    check_bit("drop_no_poison", ins_valid && (ins == POISON), 1'b0);
    check_bit("drop_req_valid", req_valid, 1'b1);
    check("lit_drop_req_addr", req_addr, 32'h8000_0100);

    // redirect coincident with the response
    lat = 2; req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    wait_resp(10);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    check_bit("coinc_ins_valid", ins_valid, 1'b0);
    check("lit_coinc_req_addr", req_addr, 32'h8000_0200);

    // wrap of the sequential PC past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("lit_wrap_req_addr", req_addr, 32'hFFFF_FFFC);
    req_ready = 1'b1; lat = 1; ins_ready = 1'b1;
    wait_ins(10);
    check("lit_wrap_ins_pc", ins_pc, 32'hFFFF_FFFC);
    check("lit_wrap_ins", ins, 32'hFFFC_A5A5);
    req_ready = 1'b0;
    tick();
    check("lit_wrap_next_addr", req_addr, 32'h0000_0000);

    // redirect while holding an instruction
    req_ready = 1'b1; ins_ready = 1'b0;
    wait_ins(10);
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    check_bit("hold_redir_ins_valid", ins_valid, 1'b0);
    check("lit_hold_redir_addr", req_addr, 32'h8000_0300);

    // reset during WAIT, stale response afterwards
    lat = 3; req_ready = 1'b1; ins_ready = 1'b1;
    tick();
    req_ready = 1'b0; rst = 1'b1;
    #1;
    check_bit("midrst_req_valid", req_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("lit_midrst_req_addr", req_addr, 32'h8000_0000);
    tick();
    tick();
    check_bit("stale_ins_valid", ins_valid, 1'b0);
    check_bit("stale_req_valid", req_valid, 1'b1);
    check("lit_stale_req_addr", req_addr, 32'h8000_0000);
    req_ready = 1'b1; lat = 1;
    wait_ins(10);
    check("lit_refetch_ins", ins, 32'h0000_0413);
    check("lit_refetch_ins_pc", ins_pc, 32'h8000_0000);
    req_ready = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24080018_fetch.md
YSYX_24080018_FETCH -- requirements
Module: ysyx_24080018_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL have parameter INST_W, default 32, instruction and address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Ports clk and rst are named accordingly.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port req_valid, output, 1: instruction-memory read request.
REQ-007 SHALL have port req_addr, output, 32: fetch address; word-aligned.
REQ-008 SHALL have port req_ready, input, 1: memory accepts request.
REQ-009 SHALL have port resp_valid, input, 1: read data valid.
REQ-010 SHALL have port resp_data, input, 32: fetched instruction word.
REQ-011 SHALL have port ins_valid, output, 1: instruction available to decode.
REQ-012 SHALL have port ins_ready, input, 1: decode accepts instruction.
REQ-013 SHALL have port ins, output, 32: registered instruction word.
REQ-014 SHALL have port ins_pc, output, 32: PC of ins.
REQ-015 SHALL have port redirect_valid, input, 1: branch or jump redirect from execute.
REQ-016 SHALL have port redirect_pc, input, 32: redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-017 SHALL implement a three-state FSM: REQ (req_valid=1, req_addr=pc), WAIT (one request outstanding), HOLD (ins_valid=1).
REQ-018 SHALL transition REQ->WAIT on req_valid&req_ready. req_addr is held stable until acceptance.
REQ-019 SHALL, in WAIT on resp_valid with no drop flag set: capture ins<=resp_data and ins_pc<=pc, set pc<=pc+4 (mod 2^32), and go to HOLD.
REQ-020 SHALL transition HOLD->REQ on ins_valid&ins_ready. ins and ins_pc stay constant while stalled.
REQ-021 SHALL ignore resp_valid outside WAIT.
REQ-022 SHALL, on redirect_valid in any state: pc<={redirect_pc[31:2],2'b00}. Redirect has priority over every other event that cycle.
REQ-023 SHALL handle redirect in REQ without acceptance: go to REQ; req_addr shows the new pc in the next cycle.
REQ-024 SHALL handle redirect in REQ with same-cycle acceptance: go to WAIT with drop=1.
REQ-025 SHALL handle redirect in WAIT without resp_valid: set drop=1 and stay in WAIT.
REQ-026 SHALL handle redirect in WAIT with same-cycle resp_valid: discard the response and go to REQ.
REQ-027 SHALL, in WAIT with drop=1 and resp_valid (no redirect): discard the response, clear drop, and go to REQ.
REQ-028 SHALL handle redirect in HOLD: clear ins_valid and go to REQ. A same-cycle ins_ready still counts as a completed transfer.
REQ-029 SHALL keep at most one memory request outstanding at any time.
REQ-030 SHALL have latency: request accepted at cycle N, resp_valid at N+k, ins_valid at N+k+1. Peak throughput is 1 instruction per 3 cycles.

Reset
REQ-031 SHALL on rst assert set pc=RESET_PC, state=REQ, drop=0, ins_valid=0, ins=0, ins_pc=0.
REQ-032 SHALL drive req_valid=0 while rst=1, and req_valid=1 with req_addr=RESET_PC in the first cycle after deassertion.
REQ-033 SHALL, on reset asserted mid-WAIT, forget the outstanding request. A late resp_valid arriving in REQ is ignored per REQ-021.

Structure
REQ-034 SHALL take RESET_PC default, INST_W, and the FSM state enum (REQ/WAIT/HOLD) from shared package ysyx_24080018_pkg.
REQ-035 SHALL hold the PC plus its next-PC mux (pc+4 / redirect) in sub-module ysyx_24080018_pc_reg. The FSM, drop flag, and output register stay in the top.
REQ-036 SHALL be 120-400 lines of RTL with no DPI calls. Memory is modelled only in the bench.

Verification
REQ-037 Reset release, req_ready=1, resp 1 cycle later with 32'h00000413, ins_ready=1 -> req_addr 0x80000000, then ins=0x00000413 and ins_pc=0x80000000, then next req_addr 0x80000004.
REQ-038 ins_ready=0 for 5 cycles in HOLD -> ins and ins_pc constant, req_valid=0, no pc advance.
REQ-039 Redirect to 0x80000103 during WAIT, then resp 0xDEADBEEF -> response dropped, next req_addr 0x80000100, ins_valid never shows 0xDEADBEEF.
REQ-040 Redirect coincident with resp_valid in WAIT -> no ins_valid, next req_addr = redirect target.
REQ-041 pc=0xFFFFFFFC fetch completes -> next req_addr 0x00000000.
REQ-042 rst pulsed while in WAIT, stale resp_valid afterward -> ignored, first req_addr 0x80000000.
